// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction sequencer (FETCH/EXEC/MEM/WB/HALT), optional ILLEGAL_TRAP_EN
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [2:0]  state,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_en,
    output logic        rw,
    output logic        sys_dne,
    output logic        ill
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE,
        K_LI,
        K_LW,
        K_SW,
        K_HALT,
        K_ILL
    } kind_t;

    // Opcode/funct classification shared by the fetch path and the latched IR.
    function automatic kind_t classify(input logic [5:0] opcode, input logic [5:0] funct);
        kind_t k;
        k = K_ILL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_RTYPE;
                    default:                           k = K_ILL;
                endcase
            end
            6'h0A:   k = K_LI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h3F:   k = K_HALT;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;
    kind_t       ir_kind;
    kind_t       fetch_kind;

    // The next path is chosen from the live instruction while fetching; afterwards only IR matters.
    assign fetch_kind = classify(instruction[31:26], instruction[5:0]);
    assign ir_kind    = classify(ir_q[31:26], ir_q[5:0]);
    assign state      = state_q;

    // State register and instruction register; IR only loads in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                ir_q <= instruction;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;

    // Sticky trap flag, set when an illegal instruction is fetched; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (state_q == FETCH && fetch_kind == K_ILL) begin
            trap_q <= 1'b1;
        end
    end

    assign ill = trap_q;
`else
    assign ill = 1'b0;
`endif

    // Next-state selection per instruction class.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                case (fetch_kind)
                    K_RTYPE, K_LW, K_SW: state_d = EXEC;
                    K_LI:                state_d = WB;
                    K_HALT:              state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_d = HALT;
`else
                    default:             state_d = EXEC;
`endif
                endcase
            end
            EXEC: begin
                case (ir_kind)
                    K_LW, K_SW: state_d = MEM;
                    K_RTYPE:    state_d = WB;
                    default:    state_d = FETCH;
                endcase
            end
            MEM:     state_d = (ir_kind == K_LW) ? WB : FETCH;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Decode outputs from IR; controls are only driven in the state that consumes them.
    always_comb begin
        rd      = 5'd0;
        rs      = 5'd0;
        rt      = 5'd0;
        imm     = {{16{ir_q[15]}}, ir_q[15:0]};
        alu_op  = 4'd0;
        alu_src = 1'b0;
        wb_sel  = 2'd0;
        reg_we  = 1'b0;
        mem_en  = 1'b0;
        rw      = 1'b0;
        sys_dne = 1'b0;

        case (ir_kind)
            K_RTYPE: begin
                rs = ir_q[25:21];
                rt = ir_q[20:16];
                rd = ir_q[15:11];
            end
            K_LI: rd = ir_q[25:21];
            K_LW: begin
                rs = ir_q[25:21];
                rd = ir_q[20:16];
            end
            K_SW: begin
                rs = ir_q[25:21];
                rt = ir_q[20:16];
            end
            default: ;
        endcase

        case (state_q)
            EXEC: begin
                if (ir_kind == K_RTYPE) begin
                    case (ir_q[5:0])
                        6'h22:   alu_op = 4'd1;
                        6'h24:   alu_op = 4'd2;
                        6'h25:   alu_op = 4'd3;
                        6'h2A:   alu_op = 4'd4;
                        default: alu_op = 4'd0;
                    endcase
                end
                alu_src = (ir_kind == K_LW) || (ir_kind == K_SW);
            end
            MEM: begin
                mem_en = 1'b1;
                rw     = (ir_kind == K_SW);
            end
            WB: begin
                case (ir_kind)
                    K_LI:    wb_sel = 2'd1;
                    K_LW:    wb_sel = 2'd2;
                    default: wb_sel = 2'd0;
                endcase
                // Register 0 is read-only, so a write to it never strobes.
                reg_we = (ir_kind == K_RTYPE || ir_kind == K_LI || ir_kind == K_LW) && (rd != 5'd0);
            end
            HALT:    sys_dne = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [2:0]  state;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_en;
    logic        rw;
    logic        sys_dne;
    logic        ill;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .state       (state),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .mem_en      (mem_en),
        .rw          (rw),
        .sys_dne     (sys_dne),
        .ill         (ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic        we;
        logic        men;
        logic        rwr;
        logic        dne;
        logic        il;
        logic [1:0]  wbs;
        logic [3:0]  aop;
        logic        asrc;
        logic        c_rd;
        logic        c_rs;
        logic        c_rt;
        logic        c_imm;
        logic [4:0]  erd;
        logic [4:0]  ers;
        logic [4:0]  ert;
        logic [31:0] eimm;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t blank(input string tag, input logic [2:0] st);
        exp_t e;
        e.tag = tag; e.st = st;
        e.we = 1'b0; e.men = 1'b0; e.rwr = 1'b0; e.dne = 1'b0; e.il = 1'b0;
        e.wbs = 2'd0; e.aop = 4'd0; e.asrc = 1'b0;
        e.c_rd = 1'b0; e.c_rs = 1'b0; e.c_rt = 1'b0; e.c_imm = 1'b0;
        e.erd = 5'd0; e.ers = 5'd0; e.ert = 5'd0; e.eimm = 32'd0;
        return e;
    endfunction

    // One clock: sample after the edge and compare against the oldest expectation.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check({e.tag, ".state"},   32'(state),   32'(e.st));
            check({e.tag, ".reg_we"},  32'(reg_we),  32'(e.we));
            check({e.tag, ".mem_en"},  32'(mem_en),  32'(e.men));
            check({e.tag, ".rw"},      32'(rw),      32'(e.rwr));
            check({e.tag, ".sys_dne"}, 32'(sys_dne), 32'(e.dne));
            check({e.tag, ".ill"},     32'(ill),     32'(e.il));
            check({e.tag, ".wb_sel"},  32'(wb_sel),  32'(e.wbs));
            check({e.tag, ".alu_op"},  32'(alu_op),  32'(e.aop));
            check({e.tag, ".alu_src"}, 32'(alu_src), 32'(e.asrc));
            if (e.c_rd)  check({e.tag, ".rd"},  32'(rd), 32'(e.erd));
            if (e.c_rs)  check({e.tag, ".rs"},  32'(rs), 32'(e.ers));
            if (e.c_rt)  check({e.tag, ".rt"},  32'(rt), 32'(e.ert));
            if (e.c_imm) check({e.tag, ".imm"}, imm,     e.eimm);
            // Outside FETCH the instruction bus must be ignored, so disturb it.
            if (e.st != 3'd0) instruction = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = sbq.size();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        sbq.push_back(blank(tag, 3'd0));
        step();
        reset = 1'b0;
    endtask

    // Reference behaviour: push the expected per-cycle outputs for one instruction.
    task automatic issue(input logic [31:0] w, input string tag);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  f_rs, f_rt, f_rd;
        logic [31:0] sx;
        logic [3:0]  aop;
        bit          ok;
        op = w[31:26]; fn = w[5:0];
        f_rs = w[25:21]; f_rt = w[20:16]; f_rd = w[15:11];
        sx = {{16{w[15]}}, w[15:0]};
        instruction = w;
        ok = 1'b1; aop = 4'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: aop = 4'd0;
                6'h22: aop = 4'd1;
                6'h24: aop = 4'd2;
                6'h25: aop = 4'd3;
                6'h2A: aop = 4'd4;
                default: ok = 1'b0;
            endcase
        end
        if (op == 6'h00 && ok) begin
            e = blank({tag, ".exec"}, 3'd1);
            e.aop = aop; e.c_rs = 1; e.ers = f_rs; e.c_rt = 1; e.ert = f_rt;
            sbq.push_back(e);
            e = blank({tag, ".wb"}, 3'd3);
            e.we = (f_rd != 5'd0); e.c_rd = 1; e.erd = f_rd;
            sbq.push_back(e);
            sbq.push_back(blank({tag, ".fetch"}, 3'd0));
        end else if (op == 6'h0A) begin
            e = blank({tag, ".wb"}, 3'd3);
            e.we = (f_rs != 5'd0); e.wbs = 2'd1; e.c_rd = 1; e.erd = f_rs; e.c_imm = 1; e.eimm = sx;
            sbq.push_back(e);
            sbq.push_back(blank({tag, ".fetch"}, 3'd0));
        end else if (op == 6'h23) begin
            e = blank({tag, ".exec"}, 3'd1);
            e.asrc = 1; e.c_rs = 1; e.ers = f_rs; e.c_imm = 1; e.eimm = sx;
            sbq.push_back(e);
            e = blank({tag, ".mem"}, 3'd2);
            e.men = 1;
            sbq.push_back(e);
            e = blank({tag, ".wb"}, 3'd3);
            e.we = (f_rt != 5'd0); e.wbs = 2'd2; e.c_rd = 1; e.erd = f_rt;
            sbq.push_back(e);
            sbq.push_back(blank({tag, ".fetch"}, 3'd0));
        end else if (op == 6'h2B) begin
            e = blank({tag, ".exec"}, 3'd1);
            e.asrc = 1; e.c_rs = 1; e.ers = f_rs; e.c_rt = 1; e.ert = f_rt; e.c_imm = 1; e.eimm = sx;
            sbq.push_back(e);
            e = blank({tag, ".mem"}, 3'd2);
            e.men = 1; e.rwr = 1;
            sbq.push_back(e);
            sbq.push_back(blank({tag, ".fetch"}, 3'd0));
        end else if (op == 6'h3F) begin
            e = blank({tag, ".halt"}, 3'd4);
            e.dne = 1;
            sbq.push_back(e);
        end else begin
`ifdef ILLEGAL_TRAP_EN
            e = blank({tag, ".trap"}, 3'd4);
            e.dne = 1; e.il = 1;
            sbq.push_back(e);
`else
            sbq.push_back(blank({tag, ".nop_exec"}, 3'd1));
            sbq.push_back(blank({tag, ".nop_fetch"}, 3'd0));
`endif
        end
        drain();
    endtask

    logic [5:0] functs [5];

    initial begin
        exp_t e;
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2A;
        reset = 1'b1;
        instruction = 32'h0;
        do_reset("reset");

        issue(32'h2B40FA37, "li");
        issue(32'h28001234, "li_r0");
        issue(32'h00221820, "add");
        issue(32'h8C250010, "lw");
        issue(32'hAC250010, "sw");
        issue(32'h00000020, "add_r0");

        for (int i = 0; i < 8; i++) begin
            issue({6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, functs[$urandom_range(0, 4)]}, "rnd_r");
            issue({6'h0A, 5'($urandom), 5'($urandom), 16'($urandom)}, "rnd_li");
        end

        // Reset while an LW sits in MEM: no write-back may follow.
        instruction = 32'h8C250010;
        e = blank("lw_abort.exec", 3'd1);
        e.asrc = 1; e.c_rs = 1; e.ers = 5'd1;
        sbq.push_back(e);
        e = blank("lw_abort.mem", 3'd2);
        e.men = 1;
        sbq.push_back(e);
        drain();
        do_reset("lw_abort.reset");
        issue(32'h00000020, "after_abort");

        // HALT is absorbing until reset.
        issue(32'hFC000000, "halt");
        for (int i = 0; i < 5; i++) begin
            e = blank("halt_hold", 3'd4);
            e.dne = 1;
            sbq.push_back(e);
            step();
        end
        do_reset("halt_reset");

        issue(32'h04000000, "ill_op");
        do_reset("ill_op_reset");
        issue(32'h00221821, "ill_funct");
        do_reset("ill_funct_reset");
        issue(32'h00221822, "sub_after_ill");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
